// File: rtl/fx_iter_divsqrt_pkg.sv
// rtl/fx_iter_divsqrt_pkg.sv - shared op/state encodings and range constants for the divide/sqrt unit
package fx_iter_divsqrt_pkg;

    typedef enum logic {
        FX_DIV  = 1'b0,
        FX_SQRT = 1'b1
    } fx_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } fx_ds_state_e;

    localparam int FX_WIDTH = 32;
    localparam logic [FX_WIDTH-1:0] FX_MAX_POS = {1'b0, {(FX_WIDTH-1){1'b1}}};
    localparam logic [FX_WIDTH-1:0] FX_MIN_NEG = {1'b1, {(FX_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fx_iter_divsqrt_sign_fixup.sv
// rtl/fx_iter_divsqrt_sign_fixup.sv - magnitude+sign to two's complement with overflow detect
// Clamps on overflow when FX_DIVSQRT_SATURATE_EN is defined, otherwise keeps the wrapped low bits.
module fx_sign_fixup #(
    parameter int WIDTH = 32,
    parameter int MAG_W = 48
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    // Negative results may reach one step further than positive ones (-2^(WIDTH-1)).
    localparam logic [MAG_W-1:0] LIM_POS = {{(MAG_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [MAG_W-1:0] LIM_NEG = LIM_POS + MAG_W'(1);
`ifdef FX_DIVSQRT_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        ovf    = neg ? (mag > LIM_NEG) : (mag > LIM_POS);
        result = neg ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
`ifdef FX_DIVSQRT_SATURATE_EN
        if (ovf) begin
            result = neg ? MIN_NEG : MAX_POS;
        end
`endif
    end

endmodule

// File: rtl/fx_iter_divsqrt.sv
// rtl/fx_iter_divsqrt.sv - iterative signed fixed-point divide / square root, one result bit per clock
// Overflow behaviour selected by FX_DIVSQRT_SATURATE_EN (clamp) or its absence (wrap).
module fx_iter_divsqrt
    import fx_iter_divsqrt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             out_ovf
);

    localparam int DW = WIDTH + FRAC;
    localparam int RW = WIDTH + 1;
    localparam int CW = $clog2(DW + 1);

    localparam logic [CW-1:0] N_DIV_M1  = CW'(DW - 1);
    localparam logic [CW-1:0] N_SQRT_M1 = CW'(DW / 2 - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ITER  = ITER;
    localparam logic [1:0] S_FIXUP = FIXUP;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    work_q, work_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    logic             op_q, op_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [RW:0]      rs, trial;
    logic             fits;
    logic [RW-1:0]    rem_next;
    logic [DW-1:0]    work_next;
    logic [WIDTH-1:0] fix_result;
    logic             fix_ovf;

    assign a_abs = in_a[WIDTH-1] ? -in_a : in_a;
    assign b_abs = in_b[WIDTH-1] ? -in_b : in_b;

    // Shared step: DIV brings in one dividend bit against |b|, SQRT two radicand bits against 4*root+1.
    always_comb begin
        if (op_q == FX_SQRT) begin
            rs        = {rem_q[RW-2:0], work_q[DW-1:DW-2]};
            trial     = {quo_q[RW-2:0], 2'b01};
            work_next = {work_q[DW-3:0], 2'b00};
        end else begin
            rs        = {rem_q, work_q[DW-1]};
            trial     = {2'b00, babs_q};
            work_next = {work_q[DW-2:0], 1'b0};
        end
        fits     = (rs >= trial);
        rem_next = fits ? (rs[RW-1:0] - trial[RW-1:0]) : rs[RW-1:0];
    end

    fx_sign_fixup #(
        .WIDTH (WIDTH),
        .MAG_W (DW)
    ) u_sign_fixup (
        .mag    (quo_q),
        .neg    (neg_q),
        .result (fix_result),
        .ovf    (fix_ovf)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        work_d       = work_q;
        quo_d        = quo_q;
        babs_d       = babs_q;
        op_d         = op_q;
        neg_d        = neg_q;
        err_d        = err_q;
        tag_d        = tag_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        out_ovf_d    = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = in_op;
                    tag_d  = in_tag;
                    rem_d  = '0;
                    quo_d  = '0;
                    babs_d = b_abs;
                    err_d  = 1'b0;
                    if (in_op == FX_SQRT) begin
                        neg_d  = 1'b0;
                        work_d = {in_a, {FRAC{1'b0}}};
                        cnt_d  = N_SQRT_M1;
                        if (in_a[WIDTH-1]) begin
                            err_d   = 1'b1;
                            state_d = S_FIXUP;
                        end else begin
                            state_d = S_ITER;
                        end
                    end else begin
                        work_d = {a_abs, {FRAC{1'b0}}};
                        cnt_d  = N_DIV_M1;
                        if (in_b == '0) begin
                            // neg_q carries the dividend sign so FIXUP can pick the saturation rail.
                            err_d   = 1'b1;
                            neg_d   = in_a[WIDTH-1];
                            state_d = S_FIXUP;
                        end else begin
                            neg_d   = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                            state_d = S_ITER;
                        end
                    end
                end
            end
            S_ITER: begin
                rem_d  = rem_next;
                work_d = work_next;
                quo_d  = {quo_q[DW-2:0], fits};
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIXUP: begin
                out_tag_d = tag_q;
                out_err_d = err_q;
                if (err_q) begin
                    out_result_d = (op_q == FX_SQRT) ? '0 : (neg_q ? MIN_NEG : MAX_POS);
                    out_ovf_d    = 1'b0;
                end else begin
                    out_result_d = fix_result;
                    out_ovf_d    = fix_ovf;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            work_q       <= '0;
            quo_q        <= '0;
            babs_q       <= '0;
            op_q         <= 1'b0;
            neg_q        <= 1'b0;
            err_q        <= 1'b0;
            tag_q        <= '0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            work_q       <= work_d;
            quo_q        <= quo_d;
            babs_q       <= babs_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            err_q        <= err_d;
            tag_q        <= tag_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_fx_iter_divsqrt.sv
// tb/tb_fx_iter_divsqrt.sv - reference-model bench for fx_iter_divsqrt (WIDTH=32, FRAC=16)
module tb_fx_iter_divsqrt;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  tag;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [7:0]  out_tag;
    logic        out_err;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    fx_iter_divsqrt #(.WIDTH(32), .FRAC(16), .TAG_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued meaning of the operands.
    function automatic exp_t model(logic op, logic [31:0] a, logic [31:0] b, logic [7:0] tag);
        exp_t e;
        longint unsigned ua, ub, q, lim, x, lo, hi, mid;
        logic s;
        logic [63:0] sq;
        e.tag = tag; e.err = 1'b0; e.ovf = 1'b0; e.res = '0;
        if (op == 1'b0) begin
            if (b == 32'd0) begin
                e.err = 1'b1;
                e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                ua  = a[31] ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
                ub  = b[31] ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
                s   = a[31] ^ b[31];
                q   = (ua << 16) / ub;
                lim = s ? 64'h8000_0000 : 64'h7FFF_FFFF;
                e.ovf = (q > lim);
                sq  = s ? (64'd0 - q) : q;
                e.res = sq[31:0];
`ifdef FX_DIVSQRT_SATURATE_EN
                if (e.ovf) e.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            end
        end else if (a[31]) begin
            e.err = 1'b1;
        end else begin
            x  = {32'd0, a} << 16;
            lo = 0;
            hi = 64'h1_0000_0000;
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (mid * mid <= x) lo = mid;
                else hi = mid - 1;
            end
            e.res = lo[31:0];
        end
        return e;
    endfunction

    // Compare process: scoreboard on every handshake, hold/stability and busy checks every cycle.
    logic        p_valid, p_ready, p_err, p_ovf;
    logic [31:0] p_res;
    logic [7:0]  p_tag;
    initial p_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            p_valid = 1'b0;
        end else begin
            if (out_valid)
                chk(in_ready == 1'b0, "in_ready_low_while_busy", in_ready, 0);
            if (p_valid && !p_ready)
                chk(out_valid && out_result == p_res && out_tag == p_tag && out_err == p_err && out_ovf == p_ovf,
                    "outputs_held", {out_valid, out_result}, {1'b1, p_res});
            if (out_err && out_ovf)
                chk(1'b0, "err_and_ovf_both", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", out_result, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(out_result == e.res && out_tag == e.tag && out_err == e.err && out_ovf == e.ovf,
                        "model_result", {out_tag, out_err, out_ovf, out_result}, {e.tag, e.err, e.ovf, e.res});
                end
            end
            p_valid = out_valid; p_ready = out_ready; p_res = out_result;
            p_tag = out_tag; p_err = out_err; p_ovf = out_ovf;
        end
    end

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                          input int hold, output int lat, output logic [31:0] res, output logic [7:0] tg,
                          output logic err, output logic ovf);
        int k;
        k = 0;
        res = '0; tg = '0; err = 1'b0; ovf = 1'b0; lat = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            chk(1'b0, "in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        exp_q.push_back(model(op, a, b, tag));
        do begin
            @(posedge clk); #1;
            if (lat == 0) begin
                in_valid = 1'b0; in_op = 1'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 8'($urandom);
            end
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) begin
            chk(1'b0, "out_valid_timeout", lat, 0);
            exp_q.delete();
            return;
        end
        repeat (hold) @(posedge clk);
        #1;
        res = out_result; tg = out_tag; err = out_err; ovf = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand(int cls);
        case (cls)
            0: return $urandom;
            1: return $urandom_range(0, 32'h0004_0000);
            2: return 32'd0 - $urandom_range(1, 32'h0004_0000);
            3: return 32'h8000_0000;
            4: return 32'd0;
            default: return $urandom_range(1, 255);
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] res;
        logic [7:0] tg;
        logic err, ovf;
        logic seen_valid;
        logic [31:0] ovf_req;

        reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(out_result == 32'd0 && out_tag == 8'd0, "reset_outputs", {out_tag, out_result}, 0);
        chk(out_err == 1'b0 && out_ovf == 1'b0, "reset_flags", {out_err, out_ovf}, 0);
        @(posedge clk); #1;

        run_op(1'b0, 32'h0003_0000, 32'h0002_0000, 8'h11, 0, lat, res, tg, err, ovf);
        chk(lat == 50, "div_latency", lat, 50);
        chk(res == 32'h0001_8000 && !err && !ovf, "div_3_by_2", res, 32'h0001_8000);

        run_op(1'b0, 32'hFFFE_8000, 32'h0000_8000, 8'h5A, 2, lat, res, tg, err, ovf);
        chk(res == 32'hFFFD_0000, "div_neg", res, 32'hFFFD_0000);
        chk(tg == 8'h5A, "div_tag", tg, 8'h5A);

        run_op(1'b1, 32'h0002_4000, 32'h1234_5678, 8'h22, 0, lat, res, tg, err, ovf);
        chk(lat == 26, "sqrt_latency", lat, 26);
        chk(res == 32'h0001_8000 && !err, "sqrt_2p25", res, 32'h0001_8000);

        run_op(1'b1, 32'hFFFF_0000, 32'h0, 8'h23, 0, lat, res, tg, err, ovf);
        chk(res == 32'd0 && err == 1'b1 && lat == 2, "sqrt_negative", {lat, err, res}, {32'd2, 1'b1, 32'd0});

        run_op(1'b0, 32'h0001_0000, 32'h0, 8'h24, 0, lat, res, tg, err, ovf);
        chk(res == 32'h7FFF_FFFF && err == 1'b1 && lat == 2, "div_by_zero_pos", {lat, err, res}, {32'd2, 1'b1, 32'h7FFF_FFFF});

        run_op(1'b0, 32'hFFFF_0000, 32'h0, 8'h25, 0, lat, res, tg, err, ovf);
        chk(res == 32'h8000_0000 && err == 1'b1, "div_by_zero_neg", res, 32'h8000_0000);

`ifdef FX_DIVSQRT_SATURATE_EN
        ovf_req = 32'h7FFF_FFFF;
`else
        ovf_req = 32'h0000_0000;
`endif
        run_op(1'b0, 32'h4000_0000, 32'h0000_0001, 8'h26, 0, lat, res, tg, err, ovf);
        chk(ovf == 1'b1 && err == 1'b0 && res == ovf_req, "div_overflow", {ovf, err, res}, {1'b1, 1'b0, ovf_req});

        run_op(1'b0, 32'h0007_0000, 32'hFFFE_0000, 8'h27, 10, lat, res, tg, err, ovf);
        chk(res == 32'hFFFC_8000, "backpressure_result", res, 32'hFFFC_8000);

        in_valid = 1'b1; in_op = 1'b0; in_a = 32'h0003_0000; in_b = 32'h0002_0000; in_tag = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk(in_ready == 1'b1 && out_valid == 1'b0, "midop_reset_handshake", {in_ready, out_valid}, 2'b10);
        chk(out_result == 32'd0 && out_tag == 8'd0 && !out_err && !out_ovf, "midop_reset_outputs",
            {out_tag, out_result}, 0);
        seen_valid = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk(seen_valid == 1'b0, "no_stale_out_valid", seen_valid, 0);

        for (int i = 0; i < 150; i++) begin
            logic o;
            logic [31:0] ra, rb;
            o  = 1'($urandom);
            ra = pick_operand($urandom_range(0, 5));
            rb = pick_operand($urandom_range(0, 5));
            run_op(o, ra, rb, 8'($urandom), $urandom_range(0, 3), lat, res, tg, err, ovf);
            if (!err)
                chk(lat == (o ? 26 : 50), "rand_latency", lat, o ? 26 : 50);
        end

        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
